// File: rtl/ahb_prot_pkg.sv
// ahb_prot_pkg
//   Shared definitions for the AHB-Lite protection checker:
//   - HTRANS encodings
//   - HPROT bit positions
//   - region_attr bit positions
//   - error-response FSM state encoding
//   - a helper that evaluates the per-attribute access checks
package ahb_prot_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int HPROT_DATA  = 0;
  localparam int HPROT_PRIV  = 1;
  localparam int HPROT_BUF   = 2;
  localparam int HPROT_CACHE = 3;

  // region_attr slice layout is {ro, xn, priv_only}
  localparam int ATTR_PRIV_ONLY = 0;
  localparam int ATTR_XN        = 1;
  localparam int ATTR_RO        = 2;
  localparam int ATTR_W         = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ERR1 = 2'b01,
    ST_ERR2 = 2'b10
  } err_state_e;

  // Returns one failure flag per attribute, laid out like region_attr.
  function automatic logic [ATTR_W-1:0] attr_fail(
    input logic [ATTR_W-1:0] attr,
    input logic              write,
    input logic [1:0]        hprot_lo
  );
    logic [ATTR_W-1:0] f;
    f[ATTR_PRIV_ONLY] = attr[ATTR_PRIV_ONLY] & ~hprot_lo[HPROT_PRIV];
    f[ATTR_XN]        = attr[ATTR_XN]        & ~hprot_lo[HPROT_DATA];
    f[ATTR_RO]        = attr[ATTR_RO]        & write;
    return f;
  endfunction

endpackage

// File: rtl/ahb_prot_region_match.sv
// ahb_prot_region_match
//   Combinational compare of one address against NUM_REGIONS masked regions.
//   The lowest-numbered enabled region that matches wins.
// Ports:
//   i_addr       address under test
//   i_region_en  per-region enable
//   i_base       packed region base addresses
//   i_mask       packed region masks (1 = bit participates in compare)
//   i_attr       packed region attributes {ro, xn, priv_only}
//   o_hit        some enabled region matched
//   o_idx        index of the winning region
//   o_attr       attributes of the winning region (zero when no hit)
module ahb_prot_region_match
  import ahb_prot_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int NUM_REGIONS = 4,
  parameter int IDX_W       = 2
) (
  input  logic [ADDR_W-1:0]             i_addr,
  input  logic [NUM_REGIONS-1:0]        i_region_en,
  input  logic [NUM_REGIONS*ADDR_W-1:0] i_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] i_mask,
  input  logic [NUM_REGIONS*ATTR_W-1:0] i_attr,
  output logic                          o_hit,
  output logic [IDX_W-1:0]              o_idx,
  output logic [ATTR_W-1:0]             o_attr
);

  // Priority select: scanning from the top index down lets lower indices overwrite.
  always_comb begin
    o_hit  = 1'b0;
    o_idx  = {IDX_W{1'b0}};
    o_attr = {ATTR_W{1'b0}};
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (i_region_en[i] &&
          (((i_addr ^ i_base[i*ADDR_W +: ADDR_W]) & i_mask[i*ADDR_W +: ADDR_W]) == {ADDR_W{1'b0}})) begin
        o_hit  = 1'b1;
        o_idx  = IDX_W'(i);
        o_attr = i_attr[i*ATTR_W +: ATTR_W];
      end else begin
        o_hit  = o_hit;
        o_idx  = o_idx;
        o_attr = o_attr;
      end
    end
  end

endmodule

// File: rtl/ahb_prot_checker.sv
// ahb_prot_checker
//   AHB-Lite slave-side protection filter. Each address phase is classified
//   from HPROT and checked against the winning protection region. Violating
//   transfers are replaced by IDLE towards the slave and answered with a
//   two-cycle ERROR response; legal transfers pass with no added latency.
//   Sticky first-violation capture and a saturating violation count are kept.
// Ports:
//   HCLK/HRESETn                       clock, async active-low reset
//   HSEL/HADDR/HTRANS/HWRITE/HPROT/HREADY  upstream address phase
//   HREADYOUT/HRESP/HRDATA             upstream response
//   s_hsel/s_htrans                    downstream select / transfer type
//   s_hreadyout/s_hresp/s_hrdata       downstream response
//   region_en/base/mask/attr           region configuration
//   viol_clr                           clear sticky capture
//   viol_valid/addr/info/count         violation status
module ahb_prot_checker
  import ahb_prot_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int NUM_REGIONS = 4,
  parameter int CNT_W       = 8
) (
  input  logic                          HCLK,
  input  logic                          HRESETn,
  input  logic                          HSEL,
  input  logic [ADDR_W-1:0]             HADDR,
  input  logic [1:0]                    HTRANS,
  input  logic                          HWRITE,
  input  logic [3:0]                    HPROT,
  input  logic                          HREADY,
  output logic                          HREADYOUT,
  output logic                          HRESP,
  output logic [DATA_W-1:0]             HRDATA,
  output logic                          s_hsel,
  output logic [1:0]                    s_htrans,
  input  logic                          s_hreadyout,
  input  logic                          s_hresp,
  input  logic [DATA_W-1:0]             s_hrdata,
  input  logic [NUM_REGIONS-1:0]        region_en,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_base,
  input  logic [NUM_REGIONS*ADDR_W-1:0] region_mask,
  input  logic [NUM_REGIONS*ATTR_W-1:0] region_attr,
  input  logic                          viol_clr,
  output logic                          viol_valid,
  output logic [ADDR_W-1:0]             viol_addr,
  output logic [3:0]                    viol_info,
  output logic [CNT_W-1:0]              viol_count
);

  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic              w_hit;
  logic [IDX_W-1:0]  w_idx;
  logic [ATTR_W-1:0] w_attr;
  logic [ATTR_W-1:0] w_fail;
  logic              w_addr_valid;
  logic              w_viol_ph;
  logic              w_unused;
  err_state_e        r_state;
  err_state_e        w_state_nxt;
  logic              r_viol_valid;
  logic [ADDR_W-1:0] r_viol_addr;
  logic [3:0]        r_viol_info;
  logic [CNT_W-1:0]  r_viol_count;

  ahb_prot_region_match #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W)
  ) u_region_match (
    .i_addr      (HADDR),
    .i_region_en (region_en),
    .i_base      (region_base),
    .i_mask      (region_mask),
    .i_attr      (region_attr),
    .o_hit       (w_hit),
    .o_idx       (w_idx),
    .o_attr      (w_attr)
  );

  // Cacheability/bufferability and the region index do not affect the decision.
  assign w_unused     = ^{HPROT[HPROT_CACHE], HPROT[HPROT_BUF], w_idx};

  assign w_fail       = attr_fail(w_attr, HWRITE, HPROT[1:0]);
  assign w_addr_valid = HSEL & HREADY & HTRANS[1];
  assign w_viol_ph    = w_addr_valid & w_hit & (|w_fail);

  assign s_hsel       = HSEL;
  assign s_htrans     = w_viol_ph ? HTRANS_IDLE : HTRANS;

  assign viol_valid   = r_viol_valid;
  assign viol_addr    = r_viol_addr;
  assign viol_info    = r_viol_info;
  assign viol_count   = r_viol_count;

  // Error FSM next-state: a violation sampled in IDLE or ERR2 (re)starts the response.
  always_comb begin
    w_state_nxt = ST_IDLE;
    case (r_state)
      ST_IDLE: w_state_nxt = w_viol_ph ? ST_ERR1 : ST_IDLE;
      ST_ERR1: w_state_nxt = ST_ERR2;
      ST_ERR2: w_state_nxt = w_viol_ph ? ST_ERR1 : ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Error FSM state register.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Upstream response: slave pass-through unless an ERROR response is in progress.
  always_comb begin
    HREADYOUT = s_hreadyout;
    HRESP     = s_hresp;
    HRDATA    = s_hrdata;
    case (r_state)
      ST_IDLE: begin
        HREADYOUT = s_hreadyout;
        HRESP     = s_hresp;
        HRDATA    = s_hrdata;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        HRDATA    = {DATA_W{1'b0}};
      end
      ST_ERR2: begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b1;
        HRDATA    = {DATA_W{1'b0}};
      end
      default: begin
        HREADYOUT = s_hreadyout;
        HRESP     = s_hresp;
        HRDATA    = s_hrdata;
      end
    endcase
  end

  // Sticky capture of the first violation; a coincident clear lets the new one in.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_viol_valid <= 1'b0;
      r_viol_addr  <= {ADDR_W{1'b0}};
      r_viol_info  <= 4'b0000;
    end else if (w_viol_ph && (!r_viol_valid || viol_clr)) begin
      r_viol_valid <= 1'b1;
      r_viol_addr  <= HADDR;
      r_viol_info  <= {HWRITE, HPROT[HPROT_PRIV], HPROT[HPROT_DATA], w_fail[ATTR_PRIV_ONLY]};
    end else if (viol_clr) begin
      r_viol_valid <= 1'b0;
      r_viol_addr  <= {ADDR_W{1'b0}};
      r_viol_info  <= 4'b0000;
    end else begin
      r_viol_valid <= r_viol_valid;
      r_viol_addr  <= r_viol_addr;
      r_viol_info  <= r_viol_info;
    end
  end

  // Saturating violation counter; only reset clears it.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_viol_count <= {CNT_W{1'b0}};
    end else if (w_viol_ph && (r_viol_count != {CNT_W{1'b1}})) begin
      r_viol_count <= r_viol_count + CNT_W'(1);
    end else begin
      r_viol_count <= r_viol_count;
    end
  end

endmodule

// File: tb/tb_ahb_prot_checker.sv
// tb_ahb_prot_checker
//   Directed bench for ahb_prot_checker. Stimulus pushes the expected
//   response of every transfer into a queue; a monitor pops an entry at each
//   accepted address phase and checks the forwarded HTRANS and the data-phase
//   response. Status outputs are checked directly by the stimulus.
module tb_ahb_prot_checker;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int NR     = 4;
  localparam int CNT_W  = 8;

  typedef struct {
    logic              err;
    logic [1:0]        htrans;
    logic [DATA_W-1:0] rdata;
  } exp_t;

  logic                   HCLK;
  logic                   HRESETn;
  logic                   HSEL;
  logic [ADDR_W-1:0]      HADDR;
  logic [1:0]             HTRANS;
  logic                   HWRITE;
  logic [3:0]             HPROT;
  logic                   HREADY;
  logic                   HREADYOUT;
  logic                   HRESP;
  logic [DATA_W-1:0]      HRDATA;
  logic                   s_hsel;
  logic [1:0]             s_htrans;
  logic                   s_hreadyout;
  logic                   s_hresp;
  logic [DATA_W-1:0]      s_hrdata;
  logic [NR-1:0]          region_en;
  logic [NR*ADDR_W-1:0]   region_base;
  logic [NR*ADDR_W-1:0]   region_mask;
  logic [NR*3-1:0]        region_attr;
  logic                   viol_clr;
  logic                   viol_valid;
  logic [ADDR_W-1:0]      viol_addr;
  logic [3:0]             viol_info;
  logic [CNT_W-1:0]       viol_count;

  int   n_cmp;
  int   n_err;
  int   sl_cnt;
  exp_t exp_q[$];
  exp_t cur;
  logic dp_active;
  int   dp_cyc;

  ahb_prot_checker #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGIONS(NR), .CNT_W(CNT_W)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HPROT(HPROT), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
    .HRESP(HRESP), .HRDATA(HRDATA), .s_hsel(s_hsel), .s_htrans(s_htrans),
    .s_hreadyout(s_hreadyout), .s_hresp(s_hresp), .s_hrdata(s_hrdata),
    .region_en(region_en), .region_base(region_base), .region_mask(region_mask),
    .region_attr(region_attr), .viol_clr(viol_clr), .viol_valid(viol_valid),
    .viol_addr(viol_addr), .viol_info(viol_info), .viol_count(viol_count)
  );

  // Single-slave system: the bus HREADY is the checker's HREADYOUT.
  assign HREADY = HREADYOUT;

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic [DATA_W-1:0] slave_data(input logic [ADDR_W-1:0] a);
    return 32'hDEAD_BEEF ^ (a - 32'h0000_1004);
  endfunction

  // Slave model: always ready, OKAY, returns address-derived read data.
  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      s_hrdata <= 32'h0;
    end else if (HREADY) begin
      if (s_hsel && s_htrans[1]) begin
        sl_cnt   <= sl_cnt + 1;
        s_hrdata <= HWRITE ? 32'h0 : slave_data(HADDR);
      end else begin
        s_hrdata <= 32'h0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: completes the current data phase, then pops on a new address phase.
  always @(negedge HCLK) begin
    if (!HRESETn) begin
      dp_active = 1'b0;
      exp_q.delete();
    end else begin
      if (dp_active) begin
        if (cur.err) begin
          if (dp_cyc == 0) begin
            check("err1_hreadyout", {31'b0, HREADYOUT}, 32'd0);
            check("err1_hresp", {31'b0, HRESP}, 32'd1);
            dp_cyc = 1;
          end else begin
            check("err2_hreadyout", {31'b0, HREADYOUT}, 32'd1);
            check("err2_hresp", {31'b0, HRESP}, 32'd1);
            check("err2_hrdata", HRDATA, 32'h0);
            dp_active = 1'b0;
          end
        end else begin
          check("ok_hreadyout", {31'b0, HREADYOUT}, 32'd1);
          check("ok_hresp", {31'b0, HRESP}, 32'd0);
          check("ok_hrdata", HRDATA, cur.rdata);
          dp_active = 1'b0;
        end
      end
      if (HSEL && HREADY && HTRANS[1]) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_addr_phase: got addr 0x%08h expected none", HADDR);
        end else begin
          cur = exp_q.pop_front();
          check("s_htrans", {30'b0, s_htrans}, {30'b0, cur.htrans});
          dp_active = 1'b1;
          dp_cyc    = 0;
        end
      end
    end
  end

  // Issue one NONSEQ and hold it until accepted; returns just after the accepting edge.
  task automatic xfer(input logic [31:0] a, input logic w, input logic [3:0] p,
                      input logic err, input logic clr);
    exp_t e;
    logic acc;
    int   n;
    e.err    = err;
    e.htrans = err ? 2'b00 : 2'b10;
    e.rdata  = (err || w) ? 32'h0 : slave_data(a);
    exp_q.push_back(e);
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = w; HPROT = p; viol_clr = clr;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      @(negedge HCLK);
      acc = HREADY;
      @(posedge HCLK);
      #1;
      n++;
    end
    viol_clr = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: got no HREADY for addr 0x%08h expected within 20 cycles", a);
    end
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge HCLK);
      #1;
    end
  endtask

  task automatic check_status(input string tag, input logic v, input logic [31:0] a,
                              input logic [3:0] info, input logic [7:0] cnt);
    check({tag, "_valid"}, {31'b0, viol_valid}, {31'b0, v});
    check({tag, "_addr"}, viol_addr, a);
    check({tag, "_info"}, {28'b0, viol_info}, {28'b0, info});
    check({tag, "_count"}, {24'b0, viol_count}, {24'b0, cnt});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0; n_err = 0; sl_cnt = 0; dp_active = 1'b0; dp_cyc = 0;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HWRITE = 1'b0;
    HPROT = 4'b0000; viol_clr = 1'b0; s_hreadyout = 1'b1; s_hresp = 1'b0;
    region_en   = 4'b1111;
    region_base = {32'h0000_1000, 32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    region_mask = {4{32'hFFFF_F000}};
    // r3 overlaps r0 with all restrictions; r0 must win
    region_attr = {3'b111, 3'b100, 3'b010, 3'b001};

    idle(3);
    check("rst_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check("rst_hresp", {31'b0, HRESP}, 32'd0);
    check_status("rst", 1'b0, 32'h0, 4'b0000, 8'd0);
    HRESETn = 1'b1;
    idle(2);

    // priv_only region: user data read
    xfer(32'h1004, 1'b0, 4'b0001, 1'b1, 1'b0);
    check_status("priv_viol", 1'b1, 32'h1004, 4'b0011, 8'd1);
    // privileged read accepted in ERR2, forwarded
    xfer(32'h1004, 1'b0, 4'b0011, 1'b0, 1'b0);
    idle(2);
    check_status("priv_ok", 1'b1, 32'h1004, 4'b0011, 8'd1);
    // xn region: fetch then data read
    xfer(32'h2000, 1'b0, 4'b0010, 1'b1, 1'b0);
    xfer(32'h2000, 1'b0, 4'b0011, 1'b0, 1'b0);
    // ro region: write then read
    xfer(32'h3000, 1'b1, 4'b0011, 1'b1, 1'b0);
    xfer(32'h3000, 1'b0, 4'b0011, 1'b0, 1'b0);
    // privileged write in r0/r3 overlap: r0 rules, so legal
    xfer(32'h1008, 1'b1, 4'b0011, 1'b0, 1'b0);
    // unmatched address: user fetch write is legal
    xfer(32'h5000, 1'b1, 4'b0000, 1'b0, 1'b0);
    idle(2);
    check_status("after_mix", 1'b1, 32'h1004, 4'b0011, 8'd3);

    // BUSY is never checked
    HSEL = 1'b1; HADDR = 32'h1004; HTRANS = 2'b01; HPROT = 4'b0001;
    #1;
    check("busy_s_htrans", {30'b0, s_htrans}, 32'd1);
    check("busy_s_hsel", {31'b0, s_hsel}, 32'd1);
    idle(1);
    HSEL = 1'b0; HTRANS = 2'b00;
    check("busy_count", {24'b0, viol_count}, 32'd3);

    viol_clr = 1'b1;
    idle(1);
    viol_clr = 1'b0;
    check_status("clr", 1'b0, 32'h0, 4'b0000, 8'd3);

    // back-to-back: second violation sampled in ERR2
    xfer(32'h1000, 1'b0, 4'b0001, 1'b1, 1'b0);
    xfer(32'h1008, 1'b0, 4'b0001, 1'b1, 1'b0);
    check_status("b2b", 1'b1, 32'h1000, 4'b0011, 8'd5);
    idle(3);

    // clear coincident with a new violation: new capture wins
    xfer(32'h2004, 1'b0, 4'b0010, 1'b1, 1'b1);
    check_status("clr_coinc", 1'b1, 32'h2004, 4'b0100, 8'd6);

    // saturation
    for (int i = 0; i < 300; i++) begin
      xfer(32'h1004, 1'b0, 4'b0001, 1'b1, 1'b0);
      if (i == 247) check("cnt_254", {24'b0, viol_count}, 32'd254);
    end
    idle(3);
    check_status("sat", 1'b1, 32'h2004, 4'b0100, 8'd255);

    // reset in ERR1
    xfer(32'h1004, 1'b0, 4'b0001, 1'b1, 1'b0);
    HRESETn = 1'b0;
    #1;
    check("rst_err1_hreadyout", {31'b0, HREADYOUT}, 32'd1);
    check("rst_err1_hresp", {31'b0, HRESP}, 32'd0);
    check_status("rst_err1", 1'b0, 32'h0, 4'b0000, 8'd0);
    repeat (2) @(negedge HCLK);
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    xfer(32'h1004, 1'b0, 4'b0011, 1'b0, 1'b0);
    idle(4);
    check_status("post_rst", 1'b0, 32'h0, 4'b0000, 8'd0);

    check("sb_drained", exp_q.size(), 32'd0);
    check("slave_xfers", sl_cnt, 32'd6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
